// File: rtl/evm_memory_control_unit.sv
// ---------------------------------------------------------------------------
// evm_memory_control_unit
//
// Vote-storage and tally core of the electronic voting machine. Records at
// most one vote per registered voter (8 voters) for one of 4 candidates,
// keeps a saturating 3-bit tally per candidate and continuously reports the
// leading candidate together with that candidate's tally.
//
// Ports:
//   clk               in   1  system clock, all state changes on rising edge
//   reset             in   1  asynchronous, active-high; clears flags/tallies
//   candidate_number  in   2  candidate being voted for (0-3)
//   voter_number      in   3  ID of the voter casting the ballot (0-7)
//   vote_signal       in   1  level-sampled vote request
//   winner_candidate  out  2  index of the candidate with the highest tally
//   out_vote          out  3  tally of winner_candidate
// ---------------------------------------------------------------------------
module evm_memory_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] candidate_number,
    input  logic [2:0] voter_number,
    input  logic       vote_signal,
    output logic [1:0] winner_candidate,
    output logic [2:0] out_vote
);

    logic [7:0] voted;
    logic [2:0] tally [4];
    logic       accept;
    logic [1:0] best_idx;
    logic [2:0] best_val;

    // Tallies hold at 7 so an eighth vote for one candidate never wraps.
    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    // The voter flag makes a held strobe or a repeat voter idempotent.
    assign accept = vote_signal && !voted[voter_number];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            voted <= '0;
            for (int i = 0; i < 4; i++) begin
                tally[i] <= '0;
            end
        end else if (accept) begin
            voted[voter_number]     <= 1'b1;
            tally[candidate_number] <= sat_inc(tally[candidate_number]);
        end
    end

    // Strict greater-than while scanning upward keeps ties on the lowest index.
    always_comb begin
        best_idx = 2'd0;
        best_val = tally[0];
        for (int i = 1; i < 4; i++) begin
            if (tally[i] > best_val) begin
                best_idx = 2'(i);
                best_val = tally[i];
            end
        end
    end

    assign winner_candidate = best_idx;
    assign out_vote         = best_val;

endmodule

// File: tb/tb_evm_memory_control_unit.sv
module tb_evm_memory_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] candidate_number;
    logic [2:0] voter_number;
    logic       vote_signal;
    logic [1:0] winner_candidate;
    logic [2:0] out_vote;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who has voted, and raw (unbounded) vote counts.
    bit m_voted [8];
    int m_cnt   [4];

    evm_memory_control_unit dut (
        .clk              (clk),
        .reset            (reset),
        .candidate_number (candidate_number),
        .voter_number     (voter_number),
        .vote_signal      (vote_signal),
        .winner_candidate (winner_candidate),
        .out_vote         (out_vote)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic int shown(input int i);
        return (m_cnt[i] > 7) ? 7 : m_cnt[i];
    endfunction

    function automatic int m_max();
        int mx = 0;
        for (int i = 0; i < 4; i++) if (shown(i) > mx) mx = shown(i);
        return mx;
    endfunction

    function automatic int m_winner();
        for (int i = 0; i < 4; i++) if (shown(i) == m_max()) return i;
        return 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_voted[i] = 1'b0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag);
        check({tag, ".winner"}, int'(winner_candidate), m_winner());
        check({tag, ".out_vote"}, int'(out_vote), m_max());
    endtask

    // Present one vote for 'edges' rising edges; the model sees each edge.
    task automatic vote(input int v, input int c, input int edges);
        @(negedge clk);
        voter_number     = 3'(v);
        candidate_number = 2'(c);
        vote_signal      = 1'b1;
        repeat (edges) begin
            @(posedge clk);
            if (!m_voted[v]) begin
                m_voted[v] = 1'b1;
                m_cnt[c]++;
            end
        end
        @(negedge clk);
        vote_signal = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        vote_signal      = 1'b0;
        voter_number     = '0;
        candidate_number = '0;
        model_clear();
        #1;
        check("reset_hold", int'(out_vote), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("idle.winner", int'(winner_candidate), 0);
        check("idle.out_vote", int'(out_vote), 0);

        // Directed voting sequence
        vote(0, 0, 1); check_out("v0c0");
        check("v0c0.const", int'(out_vote), 1);
        vote(1, 1, 1); check_out("tie11");
        check("tie11.const", int'(winner_candidate), 0);
        vote(2, 1, 1); check_out("v2c1");
        check("v2c1.const", int'(winner_candidate), 1);
        vote(0, 1, 4); check_out("repeat_v0");
        check("repeat_v0.const", int'(out_vote), 2);
        vote(4, 2, 1); check_out("v4c2");

        // Saturation: all eight voters pick candidate 3
        apply_reset();
        check_out("sat_reset");
        for (int v = 0; v < 8; v++) vote(v, 3, 1);
        check_out("sat");
        check("sat.winner_const", int'(winner_candidate), 3);
        check("sat.out_const", int'(out_vote), 7);
        // Every flag must now be set: nobody can move the tally for candidate 0
        for (int v = 0; v < 8; v++) vote(v, 0, 2);
        check_out("sat_flags");

        // Asynchronous reset between clock edges
        apply_reset();
        vote(1, 2, 1); vote(3, 2, 1); vote(5, 0, 1);
        check_out("pre_async");
        @(negedge clk);
        #2 reset = 1'b1;
        model_clear();
        #1;
        check("async.winner", int'(winner_candidate), 0);
        check("async.out_vote", int'(out_vote), 0);
        voter_number     = 3'd0;
        candidate_number = 2'd2;
        vote_signal      = 1'b1;
        @(posedge clk); #1;
        check_out("vote_during_reset");
        // Release with the strobe still high: next edge must count
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        m_voted[0] = 1'b1;
        m_cnt[2]++;
        @(negedge clk);
        vote_signal = 1'b0;
        check_out("post_release");
        check("post_release.const", int'(winner_candidate), 2);

        // Randomized traffic with periodic resets
        for (int s = 0; s < 80; s++) begin
            if (s % 16 == 0) apply_reset();
            if ($urandom_range(0, 3) != 0)
                vote(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                     int'($urandom_range(1, 3)));
            else begin
                @(negedge clk);
                voter_number     = 3'($urandom);
                candidate_number = 2'($urandom);
                @(negedge clk);
            end
            check_out($sformatf("rand%0d", s));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
